board_scanner: RTL
==================

BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 SHALL expose vga_clk, input, 1: pixel clock; DrawX advances by one per clock.
REQ-002 SHALL expose Reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL expose DrawX, DrawY, input, 10 each: current pixel (800x525 raster, visible 640x480).
REQ-004 SHALL expose blank, input, 1: high during the visible region.
REQ-005 SHALL expose ram_addr, output, 6: board RAM read address {rank[2:0], file[2:0]}, registered.
REQ-006 SHALL expose ram_q, input, 4: board RAM piece code, valid one clock after ram_addr.
REQ-007 SHALL expose sel_valid, sel_sq[5:0], chk_valid, chk_sq[5:0], inputs: selected square and checked-king square.
REQ-008 SHALL expose offsetX, offsetY, output, 10 each: square origin (file*60, rank*60), un-shifted board coordinates.
REQ-009 SHALL expose piece_code, output, 4: piece on the current square; EMPTY when off-board.
REQ-010 SHALL expose sq_valid, selected, captured, outputs, 1 each.

Function
REQ-011 Board window SHALL be 81<=DrawX<=560 and DrawY<=479; sq_valid = in window AND blank.
REQ-012 On the clock edge with DrawX==80: col_cnt<=0, file<=0.
REQ-013 On edges with 81<=DrawX<=559: col_cnt increments; when col_cnt==59, col_cnt<=0 and file<=file+1.
REQ-014 On the edge with DrawX==799: if DrawY==524, row_cnt<=0 and rank<=0; if DrawY<479, row_cnt increments, wrapping 59->0 with rank<=rank+1; otherwise unchanged.
REQ-015 ram_addr SHALL load {rank,0} on the edge with DrawX==79, and {rank,file+1} on edges with col_cnt==58 in the window and file<7; otherwise it holds.
REQ-016 piece_code register SHALL capture ram_q on the edge with DrawX==80 and on in-window edges with col_cnt==59, so it is valid for all 60 pixels of each square.
REQ-017 piece_code output SHALL be EMPTY whenever sq_valid is low.
REQ-018 offsetX = file*60 and offsetY = rank*60, derived from registered file/rank; only multiply-by-constant (shift-add) is used, no divider.
REQ-019 sel_valid/sel_sq/chk_valid/chk_sq SHALL be latched only on the edge with DrawX==799 and DrawY==524, so changes never tear a frame.
REQ-020 selected = latched sel_valid AND latched sel_sq=={rank,file} AND sq_valid; captured is the same function using the chk inputs.
REQ-021 DrawX/DrawY values outside REQ-012..015 trigger points SHALL leave counters unchanged; no state is kept per pixel beyond counters.

Reset
REQ-022 Reset SHALL immediately clear col_cnt, row_cnt, file, rank, ram_addr, and the latched sel/chk registers to 0, and set piece_code to EMPTY.
REQ-023 After reset deassertion mid-frame, outputs SHALL be correct from the next DrawX==80 edge for horizontal state and from the next frame start for rank and sel/chk.

Structure
REQ-024 A shared package chess_pkg SHALL hold the piece-code enum (EMPTY=0, wP..wK, bP..bK), SQ_PX=60, BOARD_X0=80, BOARD_PX=480, H_TOTAL=800, V_TOTAL=525.
REQ-025 The block SHALL be a single module; the board RAM is external.

Verification
REQ-026 Reset asserted mid-line -> piece_code==EMPTY, ram_addr==0, and offsets==0 in the same cycle.
REQ-027 RAM preloaded with square 0 = wK, square 1 = wQ, DrawY=0 -> piece_code==wK for DrawX 81..140 and wQ for DrawX 141..200, with offsetX 0 then 60.
REQ-028 DrawY=479 vs 480 -> rank==7 and offsetY==420 on line 479; sq_valid==0 and piece_code==EMPTY on line 480.
REQ-029 sel_sq=9 and sel_valid=1 applied mid-frame -> selected stays 0 for the current frame; on the next frame it is high exactly for DrawY 60..119 and DrawX 141..200.
REQ-030 chk_sq=63 and chk_valid=1 -> captured is high only for DrawX 501..560 and DrawY 420..479.
REQ-031 Full-frame sweep against a scoreboard -> ram_addr sequence is {r,0}..{r,7} per line, with no read issued for file 8.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess display definitions: piece codes and raster/board geometry.
package chess_pkg;

    typedef enum logic [3:0] {
        EMPTY = 4'd0,
        wP, wN, wB, wR, wQ, wK,
        bP, bN, bB, bR, bQ, bK
    } piece_t;

    localparam int unsigned SQ_PX    = 60;
    localparam int unsigned BOARD_X0 = 80;
    localparam int unsigned BOARD_PX = 480;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;

    // Raster trigger points derived from the geometry above
    localparam logic [9:0] X_ADDR0    = 10'(BOARD_X0 - 1);            // first read of a line
    localparam logic [9:0] X_START    = 10'(BOARD_X0);                // horizontal restart
    localparam logic [9:0] X_FIRST    = 10'(BOARD_X0 + 1);            // first board pixel
    localparam logic [9:0] X_LAST     = 10'(BOARD_X0 + BOARD_PX);     // last board pixel
    localparam logic [9:0] X_CNT_LAST = 10'(BOARD_X0 + BOARD_PX - 1); // last counting edge
    localparam logic [9:0] Y_LAST     = 10'(BOARD_PX - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [5:0] SQ_LAST    = 6'(SQ_PX - 1);
    localparam logic [5:0] SQ_PRE     = 6'(SQ_PX - 2);

    // n * 60 as a shift-add: 32n + 16n + 8n + 4n
    function automatic logic [9:0] times_sq(input logic [2:0] n);
        logic [9:0] w;
        w = {7'd0, n};
        return (w << 5) + (w << 4) + (w << 3) + (w << 2);
    endfunction

endpackage

// File: rtl/board_scanner.sv
// Walks the 8x8 board in raster order, prefetches each square's piece code
// from the external board RAM and presents per-pixel square information.
module board_scanner
    import chess_pkg::*;
(
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    output logic [5:0] ram_addr,
    input  logic [3:0] ram_q,
    input  logic       sel_valid,
    input  logic [5:0] sel_sq,
    input  logic       chk_valid,
    input  logic [5:0] chk_sq,
    output logic [9:0] offsetX,
    output logic [9:0] offsetY,
    output logic [3:0] piece_code,
    output logic       sq_valid,
    output logic       selected,
    output logic       captured
);

    logic [5:0] col_cnt;
    logic [5:0] row_cnt;
    logic [2:0] file;
    logic [2:0] rank;
    piece_t     piece_q;
    logic       sel_v_q;
    logic [5:0] sel_q;
    logic       chk_v_q;
    logic [5:0] chk_q;
    logic       in_win;

    // Board window test on the current pixel
    always_comb begin
        in_win = (DrawX >= X_FIRST) && (DrawX <= X_LAST) && (DrawY <= Y_LAST);
    end

    // Horizontal pixel-in-square counter and file index
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            col_cnt <= '0;
            file    <= '0;
        end else if (DrawX == X_START) begin
            col_cnt <= '0;
            file    <= '0;
        end else if (DrawX >= X_FIRST && DrawX <= X_CNT_LAST) begin
            if (col_cnt == SQ_LAST) begin
                col_cnt <= '0;
                file    <= file + 3'd1;
            end else begin
                col_cnt <= col_cnt + 6'd1;
            end
        end
    end

    // Vertical line-in-square counter and rank index, stepped at end of line
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            row_cnt <= '0;
            rank    <= '0;
        end else if (DrawX == H_LAST) begin
            if (DrawY == V_LAST) begin
                row_cnt <= '0;
                rank    <= '0;
            end else if (DrawY < Y_LAST) begin
                if (row_cnt == SQ_LAST) begin
                    row_cnt <= '0;
                    rank    <= rank + 3'd1;
                end else begin
                    row_cnt <= row_cnt + 6'd1;
                end
            end
        end
    end

    // RAM address prefetch: issued two pixels before the square it feeds,
    // the last square of a line issues nothing further
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            ram_addr <= '0;
        end else if (DrawX == X_ADDR0) begin
            ram_addr <= {rank, 3'd0};
        end else if (in_win && col_cnt == SQ_PRE && file != 3'd7) begin
            ram_addr <= {rank, file + 3'd1};
        end
    end

    // Piece register loaded on the pixel before each square starts
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            piece_q <= EMPTY;
        end else if (DrawX == X_START || (in_win && col_cnt == SQ_LAST)) begin
            piece_q <= piece_t'(ram_q);
        end
    end

    // Highlight squares are sampled once per frame so a frame never tears
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            sel_v_q <= 1'b0;
            sel_q   <= '0;
            chk_v_q <= 1'b0;
            chk_q   <= '0;
        end else if (DrawX == H_LAST && DrawY == V_LAST) begin
            sel_v_q <= sel_valid;
            sel_q   <= sel_sq;
            chk_v_q <= chk_valid;
            chk_q   <= chk_sq;
        end
    end

    // Per-pixel outputs
    always_comb begin
        sq_valid   = in_win && blank;
        offsetX    = times_sq(file);
        offsetY    = times_sq(rank);
        piece_code = sq_valid ? piece_q : EMPTY;
        selected   = sel_v_q && (sel_q == {rank, file}) && sq_valid;
        captured   = chk_v_q && (chk_q == {rank, file}) && sq_valid;
    end

endmodule
